// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer sequencer: lane types, FSM states,
// and saturation of wide error sums back to the 16-bit error lane.
package nn_pkg;

  typedef logic [7:0]         activation_t;
  typedef logic signed [15:0] error_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BCAST,
    S_GATHER,
    S_EMIT,
    S_DELTA,
    S_SCATTER,
    S_COLLECT,
    S_SUM,
    S_BWD
  } state_t;

  function automatic error_t sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)  return 16'sh7FFF;
    if (v < -32'sd32768) return 16'sh8000;
    return error_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/layer_sequencer_fanout.sv
// M-way handshake tracker: requests each lane once while enabled, remembers
// which lanes have completed, and flags the cycle in which the last one does.
module handshake_fanout #(
  parameter int unsigned M = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [M-1:0] ack,
  output logic [M-1:0] req,
  output logic         done
);

  logic [M-1:0] mask_q;

  assign req  = enable ? ~mask_q : '0;
  assign done = enable & (&(mask_q | (req & ack)));

  // Mask is cleared whenever the owning state is not active, so entering it always starts fresh.
  always_ff @(posedge clock) begin
    if (reset || !enable) mask_q <= '0;
    else                  mask_q <= mask_q | (req & ack);
  end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: broadcasts a forward vector to M nodes and gathers their
// activations; in training, scatters deltas and sums per-node errors.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned M = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              train,
  input  logic              in_fwd_valid,
  output logic              in_fwd_ready,
  input  logic [N*8-1:0]    in_fwd_data,
  output logic              out_fwd_valid,
  input  logic              out_fwd_ready,
  output logic [M*8-1:0]    out_fwd_data,
  input  logic              in_bwd_valid,
  output logic              in_bwd_ready,
  input  logic [M*16-1:0]   in_bwd_data,
  output logic              out_bwd_valid,
  input  logic              out_bwd_ready,
  output logic [N*16-1:0]   out_bwd_data,
  output logic              node_train,
  output logic [M-1:0]      node_fwd_valid,
  input  logic [M-1:0]      node_fwd_ready,
  output logic [N*8-1:0]    node_fwd_data,
  input  logic [M-1:0]      node_act_valid,
  input  logic [M*8-1:0]    node_act_data,
  output logic [M-1:0]      node_act_ready,
  output logic [M-1:0]      node_del_valid,
  input  logic [M-1:0]      node_del_ready,
  output logic [M*16-1:0]   node_del_data,
  input  logic [M-1:0]      node_err_valid,
  input  logic [M*N*16-1:0] node_err_data,
  output logic [M-1:0]      node_err_ready
);

  localparam int unsigned AW = 16 + $clog2(M) + 1;
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

  state_t                state_q, state_d;
  logic [N*8-1:0]        fwd_q;
  logic [M*8-1:0]        act_q;
  logic [M*16-1:0]       del_q;
  error_t                err_q  [M][N];
  logic signed [AW-1:0]  acc_q  [N];
  logic signed [AW-1:0]  addend [N];
  logic [CW-1:0]         cnt_q;
  logic                  bcast_done, gather_done, scatter_done, collect_done;
  logic [M-1:0]          act_fire, err_fire;

  handshake_fanout #(.M(M)) u_bcast (
    .clock(clock), .reset(reset), .enable(state_q == S_BCAST),
    .ack(node_fwd_ready), .req(node_fwd_valid), .done(bcast_done));

  handshake_fanout #(.M(M)) u_gather (
    .clock(clock), .reset(reset), .enable(state_q == S_GATHER),
    .ack(node_act_valid), .req(node_act_ready), .done(gather_done));

  handshake_fanout #(.M(M)) u_scatter (
    .clock(clock), .reset(reset), .enable(state_q == S_SCATTER),
    .ack(node_del_ready), .req(node_del_valid), .done(scatter_done));

  handshake_fanout #(.M(M)) u_collect (
    .clock(clock), .reset(reset), .enable(state_q == S_COLLECT),
    .ack(node_err_valid), .req(node_err_ready), .done(collect_done));

  assign act_fire      = node_act_ready & node_act_valid;
  assign err_fire      = node_err_ready & node_err_valid;
  assign node_fwd_data = fwd_q;
  assign out_fwd_data  = act_q;
  assign node_del_data = del_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    in_fwd_ready  = 1'b0;
    out_fwd_valid = 1'b0;
    in_bwd_ready  = 1'b0;
    out_bwd_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_fwd_ready = 1'b1;
        if (in_fwd_valid) state_d = S_BCAST;
      end
      S_BCAST:   if (bcast_done)   state_d = S_GATHER;
      S_GATHER:  if (gather_done)  state_d = S_EMIT;
      S_EMIT: begin
        out_fwd_valid = 1'b1;
        if (out_fwd_ready) state_d = node_train ? S_DELTA : S_IDLE;
      end
      S_DELTA: begin
        in_bwd_ready = 1'b1;
        if (in_bwd_valid) state_d = S_SCATTER;
      end
      S_SCATTER: if (scatter_done) state_d = S_COLLECT;
      S_COLLECT: if (collect_done) state_d = S_SUM;
      S_SUM:     if (cnt_q == CW'(M - 1)) state_d = S_BWD;
      S_BWD: begin
        out_bwd_valid = 1'b1;
        if (out_bwd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned n = 0; n < N; n++) addend[n] = AW'(err_q[cnt_q][n]);
  end

  always_comb begin
    out_bwd_data = '0;
    for (int unsigned n = 0; n < N; n++)
      out_bwd_data[n*16 +: 16] = sat16(32'(acc_q[n]));
  end

  // Accumulators are wide enough for M full-scale errors; saturation happens only on output.
  always_ff @(posedge clock) begin
    if (reset) begin
      node_train <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (state_q == S_IDLE && in_fwd_valid) begin
        fwd_q      <= in_fwd_data;
        node_train <= train;
      end
      for (int unsigned m = 0; m < M; m++)
        if (act_fire[m]) act_q[m*8 +: 8] <= node_act_data[m*8 +: 8];
      if (state_q == S_DELTA && in_bwd_valid) del_q <= in_bwd_data;
      for (int unsigned m = 0; m < M; m++)
        for (int unsigned n = 0; n < N; n++)
          if (err_fire[m]) err_q[m][n] <= node_err_data[(m*N + n)*16 +: 16];
      if (state_q == S_COLLECT && collect_done) begin
        cnt_q <= '0;
        for (int unsigned n = 0; n < N; n++) acc_q[n] <= '0;
      end else if (state_q == S_SUM) begin
        for (int unsigned n = 0; n < N; n++) acc_q[n] <= acc_q[n] + addend[n];
        cnt_q <= (cnt_q == CW'(M - 1)) ? '0 : cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with behavioural node models.
module tb_layer_sequencer;

  localparam int N = 2;
  localparam int M = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              train = 1'b0;
  logic              in_fwd_valid = 1'b0, in_fwd_ready;
  logic [N*8-1:0]    in_fwd_data = '0;
  logic              out_fwd_valid, out_fwd_ready = 1'b0;
  logic [M*8-1:0]    out_fwd_data;
  logic              in_bwd_valid = 1'b0, in_bwd_ready;
  logic [M*16-1:0]   in_bwd_data = '0;
  logic              out_bwd_valid, out_bwd_ready = 1'b0;
  logic [N*16-1:0]   out_bwd_data;
  logic              node_train;
  logic [M-1:0]      node_fwd_valid, node_fwd_ready;
  logic [N*8-1:0]    node_fwd_data;
  logic [M-1:0]      node_act_valid, node_act_ready;
  logic [M*8-1:0]    node_act_data;
  logic [M-1:0]      node_del_valid, node_del_ready;
  logic [M*16-1:0]   node_del_data;
  logic [M-1:0]      node_err_valid, node_err_ready;
  logic [M*N*16-1:0] node_err_data;

  layer_sequencer #(.N(N), .M(M)) dut (
    .clock(clock), .reset(reset), .train(train),
    .in_fwd_valid(in_fwd_valid), .in_fwd_ready(in_fwd_ready), .in_fwd_data(in_fwd_data),
    .out_fwd_valid(out_fwd_valid), .out_fwd_ready(out_fwd_ready), .out_fwd_data(out_fwd_data),
    .in_bwd_valid(in_bwd_valid), .in_bwd_ready(in_bwd_ready), .in_bwd_data(in_bwd_data),
    .out_bwd_valid(out_bwd_valid), .out_bwd_ready(out_bwd_ready), .out_bwd_data(out_bwd_data),
    .node_train(node_train),
    .node_fwd_valid(node_fwd_valid), .node_fwd_ready(node_fwd_ready), .node_fwd_data(node_fwd_data),
    .node_act_valid(node_act_valid), .node_act_data(node_act_data), .node_act_ready(node_act_ready),
    .node_del_valid(node_del_valid), .node_del_ready(node_del_ready), .node_del_data(node_del_data),
    .node_err_valid(node_err_valid), .node_err_data(node_err_data), .node_err_ready(node_err_ready));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]         act_val   [M];
  logic signed [15:0] err_val   [M][N];
  int                 rdy_delay [M];
  int                 err_delay [M];
  int                 fwd_cnt   [M];
  int                 del_cnt   [M];

  logic [M*8-1:0]  fwd_q [$];
  logic [N*16-1:0] bwd_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M*8-1:0] exp_fwd();
    logic [M*8-1:0] r;
    for (int m = 0; m < M; m++) r[m*8 +: 8] = act_val[m];
    return r;
  endfunction

  function automatic logic [N*16-1:0] exp_bwd();
    logic [N*16-1:0] r;
    int s;
    for (int n = 0; n < N; n++) begin
      s = 0;
      for (int m = 0; m < M; m++) s += int'(err_val[m][n]);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      r[n*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  // Node models: respond one cycle after seeing a request, with per-node extra delays.
  initial begin
    logic [M-1:0] fhs, ahs, dhs, ehs, err_pend;
    int fw_wait [M];
    int ew_wait [M];
    fhs = '0; ahs = '0; dhs = '0; ehs = '0; err_pend = '0;
    node_fwd_ready = '0; node_act_valid = '0; node_act_data = '0;
    node_del_ready = '0; node_err_valid = '0; node_err_data = '0;
    for (int m = 0; m < M; m++) begin fw_wait[m] = 0; ew_wait[m] = 0; end
    forever begin
      @(negedge clock); #1;
      if (reset) begin
        node_fwd_ready = '0; node_act_valid = '0; node_del_ready = '0; node_err_valid = '0;
        fhs = '0; ahs = '0; dhs = '0; ehs = '0; err_pend = '0;
        for (int m = 0; m < M; m++) begin fw_wait[m] = 0; ew_wait[m] = 0; end
      end else begin
        for (int m = 0; m < M; m++) begin
          if (fhs[m]) begin
            node_fwd_ready[m] = 1'b0;
            node_act_valid[m] = 1'b1;
            node_act_data[m*8 +: 8] = act_val[m];
            fwd_cnt[m]++;
            fw_wait[m] = 0;
          end else if (node_fwd_valid[m] && !node_fwd_ready[m]) begin
            if (fw_wait[m] >= rdy_delay[m]) node_fwd_ready[m] = 1'b1;
            else fw_wait[m]++;
          end
          if (ahs[m]) node_act_valid[m] = 1'b0;
          if (dhs[m]) begin
            node_del_ready[m] = 1'b0;
            err_pend[m] = 1'b1;
            del_cnt[m]++;
          end else if (node_del_valid[m] && !node_del_ready[m]) begin
            node_del_ready[m] = 1'b1;
          end
          if (ehs[m]) node_err_valid[m] = 1'b0;
          if (err_pend[m]) begin
            if (ew_wait[m] >= err_delay[m]) begin
              node_err_valid[m] = 1'b1;
              for (int n = 0; n < N; n++) node_err_data[(m*N + n)*16 +: 16] = err_val[m][n];
              err_pend[m] = 1'b0;
              ew_wait[m] = 0;
            end else ew_wait[m]++;
          end
        end
        fhs = node_fwd_valid & node_fwd_ready;
        ahs = node_act_valid & node_act_ready;
        dhs = node_del_valid & node_del_ready;
        ehs = node_err_valid & node_err_ready;
      end
    end
  end

  // Scoreboard: whatever the DUT presents must match the head of the expected queue.
  initial forever begin
    @(negedge clock); #2;
    if (!reset && out_fwd_valid) begin
      if (fwd_q.size() == 0) check("fwd_unexpected", 64'(1), 64'(0));
      else begin
        check("fwd_data", 64'(out_fwd_data), 64'(fwd_q[0]));
        if (out_fwd_ready) void'(fwd_q.pop_front());
      end
    end
    if (!reset && out_bwd_valid) begin
      if (bwd_q.size() == 0) check("bwd_unexpected", 64'(1), 64'(0));
      else begin
        check("bwd_data", 64'(out_bwd_data), 64'(bwd_q[0]));
        if (out_bwd_ready) void'(bwd_q.pop_front());
      end
    end
  end

  task automatic run_fwd(input logic [N*8-1:0] din, input logic tr, input int hold,
                         input int exp_lat, input logic skew);
    int n;
    int lat;
    fwd_q.push_back(exp_fwd());
    in_fwd_data = din; train = tr; in_fwd_valid = 1'b1;
    n = 0;
    while (!in_fwd_ready && n < 50) begin @(negedge clock); n++; end
    check("fwd_accept_timeout", 64'(n >= 50), 64'(0));
    @(negedge clock);
    in_fwd_valid = 1'b0; in_fwd_data = ~din; train = ~tr;
    check("bcast_data", 64'(node_fwd_data), 64'(din));
    check("node_train", 64'(node_train), 64'(tr));
    lat = 1;
    if (skew) begin
      @(negedge clock); lat++;
      check("skew_valid", 64'(node_fwd_valid), 64'(2'b10));
    end
    while (!out_fwd_valid && lat < 100) begin @(negedge clock); lat++; end
    if (exp_lat > 0) check("fwd_latency", 64'(lat), 64'(exp_lat));
    else check("fwd_timeout", 64'(lat >= 100), 64'(0));
    repeat (hold) begin
      check("fwd_stall_in_ready", 64'(in_fwd_ready), 64'(0));
      @(negedge clock);
    end
    out_fwd_ready = 1'b1;
    @(negedge clock);
    out_fwd_ready = 1'b0;
    if (tr) check("to_delta", 64'(in_bwd_ready), 64'(1));
    else    check("to_idle", 64'(in_fwd_ready), 64'(1));
  endtask

  task automatic run_bwd(input logic [M*16-1:0] din, input int hold);
    int n;
    bwd_q.push_back(exp_bwd());
    in_bwd_data = din; in_bwd_valid = 1'b1;
    n = 0;
    while (!in_bwd_ready && n < 50) begin @(negedge clock); n++; end
    check("bwd_accept_timeout", 64'(n >= 50), 64'(0));
    @(negedge clock);
    in_bwd_valid = 1'b0; in_bwd_data = ~din;
    check("scatter_data", 64'(node_del_data), 64'(din));
    n = 0;
    while (!out_bwd_valid && n < 100) begin @(negedge clock); n++; end
    check("bwd_timeout", 64'(n >= 100), 64'(0));
    check("bwd_node_train", 64'(node_train), 64'(1));
    repeat (hold) begin
      check("bwd_stall_in_ready", 64'(in_fwd_ready), 64'(0));
      @(negedge clock);
    end
    out_bwd_ready = 1'b1;
    @(negedge clock);
    out_bwd_ready = 1'b0;
    check("bwd_to_idle", 64'(in_fwd_ready), 64'(1));
  endtask

  initial begin
    int n;
    int f0, f1, d0, d1;
    for (int m = 0; m < M; m++) begin
      rdy_delay[m] = 0; err_delay[m] = 0; fwd_cnt[m] = 0; del_cnt[m] = 0;
      act_val[m] = '0;
      for (int k = 0; k < N; k++) err_val[m][k] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_in_fwd_ready", 64'(in_fwd_ready), 64'(1));
    check("rst_valids", 64'({out_fwd_valid, out_bwd_valid, in_bwd_ready, node_fwd_valid,
                              node_act_ready, node_del_valid, node_err_ready}), 64'(0));
    check("rst_node_train", 64'(node_train), 64'(0));

    act_val[0] = 8'h80; act_val[1] = 8'h40;
    run_fwd(16'h1020, 1'b0, 0, 3, 1'b0);

    act_val[0] = 8'h11; act_val[1] = 8'h22;
    rdy_delay[1] = 5;
    f0 = fwd_cnt[0]; f1 = fwd_cnt[1];
    run_fwd(16'h3344, 1'b0, 0, 0, 1'b1);
    check("skew_hs_node0", 64'(fwd_cnt[0] - f0), 64'(1));
    check("skew_hs_node1", 64'(fwd_cnt[1] - f1), 64'(1));
    rdy_delay[1] = 0;

    act_val[0] = 8'h05; act_val[1] = 8'hFA;
    err_val[0][1] = 16'sh0010; err_val[0][0] = 16'sh0020;
    err_val[1][1] = 16'sh0030; err_val[1][0] = -16'sh0010;
    d0 = del_cnt[0]; d1 = del_cnt[1];
    run_fwd(16'h5566, 1'b1, 0, 3, 1'b0);
    run_bwd(32'h0100FF00, 0);
    check("del_hs_node0", 64'(del_cnt[0] - d0), 64'(1));
    check("del_hs_node1", 64'(del_cnt[1] - d1), 64'(1));

    err_val[0][1] = 16'sh7000; err_val[1][1] = 16'sh7000;
    err_val[0][0] = -16'sh7000; err_val[1][0] = -16'sh7000;
    run_fwd(16'h0102, 1'b1, 0, 3, 1'b0);
    run_bwd(32'h12345678, 0);

    act_val[0] = 8'hA5; act_val[1] = 8'h5A;
    err_val[0][1] = -16'sh0003; err_val[1][1] = 16'sh0100;
    err_val[0][0] = 16'sh1234;  err_val[1][0] = 16'sh0001;
    run_fwd(16'hBEEF, 1'b1, 10, 3, 1'b0);
    run_bwd(32'hCAFE0001, 10);

    err_delay[1] = 1000;
    run_fwd(16'h7788, 1'b1, 0, 3, 1'b0);
    in_bwd_data = 32'h00010002; in_bwd_valid = 1'b1;
    @(negedge clock);
    in_bwd_valid = 1'b0;
    n = 0;
    while (node_err_ready !== 2'b10 && n < 50) begin @(negedge clock); n++; end
    check("abort_reach_collect", 64'(n >= 50), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    err_delay[1] = 0;
    check("abort_valids", 64'({out_fwd_valid, out_bwd_valid, in_bwd_ready, node_fwd_valid,
                                node_act_ready, node_del_valid, node_err_ready}), 64'(0));
    check("abort_in_fwd_ready", 64'(in_fwd_ready), 64'(1));
    check("abort_node_train", 64'(node_train), 64'(0));

    act_val[0] = 8'h3C; act_val[1] = 8'hC3;
    err_val[0][1] = 16'sh0200; err_val[1][1] = -16'sh0300;
    err_val[0][0] = 16'sh0004; err_val[1][0] = 16'sh0005;
    run_fwd(16'h99AA, 1'b1, 0, 3, 1'b0);
    run_bwd(32'h0F0F_F0F0, 2);

    repeat (5) @(negedge clock);
    check("fwd_queue_drained", 64'(fwd_q.size()), 64'(0));
    check("bwd_queue_drained", 64'(bwd_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Sequences a layer of M neurons that share one N-wide input vector. Forward: broadcasts each input vector to all nodes, gathers their M activations into one output vector. Training: scatters the M downstream deltas to the nodes, then sums the per-node backward errors into one N-wide error vector for the previous layer. Sits between consecutive layers; nodes attach on the node_* side.

Parameters:
N, 2, inputs per node (vector width of the forward input and backward output)
M, 2, nodes in the layer

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
train  in  1  mode for next accepted vector; sampled on input handshake
in_fwd_valid/in_fwd_ready  in/out  1/1  upstream forward handshake
in_fwd_data  in  N*8  unsigned activations
out_fwd_valid/out_fwd_ready  out/in  1/1  downstream forward handshake
out_fwd_data  out  M*8  gathered activations, lane m = node m
in_bwd_valid/in_bwd_ready  in/out  1/1  downstream error handshake
in_bwd_data  in  M*16  signed error, lane m for node m
out_bwd_valid/out_bwd_ready  out/in  1/1  upstream error handshake
out_bwd_data  out  N*16  signed summed errors
node_train  out  1  latched train, to all nodes
node_fwd_valid  out  M  per-node input valid
node_fwd_ready  in  M  per-node input ready
node_fwd_data  out  N*8  broadcast copy of latched input
node_act_valid  in  M  node activation valid
node_act_data  in  M*8  node activations
node_act_ready  out  M  per-node accept
node_del_valid  out  M  per-node error valid
node_del_ready  in  M  per-node error ready
node_del_data  out  M*16  latched in_bwd_data lanes
node_err_valid  in  M  node backward valid
node_err_data  in  M*N*16  node backward errors
node_err_ready  out  M  per-node accept

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0; done masks cleared; node_train 0; data registers don't-care. Reset mid-transaction aborts it; no partial vector is emitted.
- IDLE: in_fwd_ready=1. On handshake latch data and train, clear masks -> BCAST. No combinational ready->valid paths.
- BCAST: node_fwd_valid[m]=~sent[m]; on node_fwd_valid[m]&node_fwd_ready[m] set sent[m]. All sent -> GATHER. Nodes may accept in any cycle order.
- GATHER: node_act_ready[m]=~got[m]; capture lane m on handshake. All got -> EMIT.
- EMIT: out_fwd_valid=1, data stable until out_fwd_ready. Handshake -> DELTA if latched train, else IDLE. Min latency input-accept to out_fwd_valid: 3 cycles.
- DELTA: in_bwd_ready=1; on handshake latch M lanes, clear masks -> SCATTER.
- SCATTER: as BCAST with node_del_* -> COLLECT.
- COLLECT: node_err_ready[m]=~got[m]; capture N lanes of node m on handshake. All got -> SUM, counter=0, accumulators=0.
- SUM: one node per cycle, M cycles; acc[n] += err[counter][n], acc width 16+clog2(M)+1 signed. counter==M-1 -> BWD.
- BWD: out_bwd_valid=1, out_bwd_data[n]=acc[n] saturated to [-32768, 32767]; hold until out_bwd_ready -> IDLE.
- node_train changes only on an IDLE handshake.
- Deadlock: a node never responding stalls indefinitely; no timeout by design.
- Counter wrap: only in SUM, resets to 0 on exit; M=1 gives one SUM cycle.

Decomposition:
- Shared package (nn_pkg): activation_t (8-bit), error_t (signed 16-bit), function sat16(wide signed) -> error_t, state enum.
- One sub-module natural: handshake_fanout (M-way valid/ready mask tracking with done flag), instantiated for BCAST, SCATTER, and reused mirrored for GATHER/COLLECT.

Test Plan:
- Inference, nodes always ready, node0 act 0x80, node1 0x40, train=0, in {0x10,0x20} -> node_fwd_data {0x10,0x20} to both; out_fwd_data {0x40,0x80} 3 cycles after accept; back to IDLE.
- Skewed readies: node1 ready 5 cycles after node0 -> node_fwd_valid[0] drops after its handshake, [1] held; exactly one handshake per node; out_fwd_data unchanged.
- Train: in_bwd {0x0100,0xFF00}; node errors n0 {0x0010,0x0020}, n1 {0x0030,0xFFF0} -> node_del_data lanes match; out_bwd_data {0x0040,0x0010}; node_train=1.
- Saturation: errors 0x7000+0x7000 and 0x9000+0x9000 -> 0x7FFF and 0x8000.
- Backpressure: out_fwd_ready low 10 cycles -> data stable, in_fwd_ready 0; out_bwd likewise.
- Reset asserted in COLLECT -> next cycle all valids 0, IDLE, in_fwd_ready=1; next transaction correct.
